// File: rtl/seq_divider_32_pkg.sv
// Shared definitions for the sequential MIPS divider: FSM states and default width.
// Also consumed by the control-unit stall logic.
package seq_divider_32_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } div_state_e;

    localparam int unsigned DEFAULT_WIDTH = 32;

endpackage

// File: rtl/seq_divider_32_div_trial_sub.sv
// Trial subtractor for one restoring-division step: (WIDTH+1)-bit a - b.
// The borrow is the MSB of the widened difference.
module div_trial_sub #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH:0]   b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    logic [WIDTH:0] full_diff;

    assign full_diff = a - b;
    assign diff      = full_diff[WIDTH-1:0];
    assign borrow    = full_diff[WIDTH];

endmodule

// File: rtl/seq_divider_32.sv
// Multi-cycle restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// signed fix-up and divide-by-zero handling in a final FIX cycle.
module seq_divider_32
    import seq_divider_32_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] orig_q, orig_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   trial_a;
    logic [WIDTH:0]   trial_b;
    logic [WIDTH-1:0] trial_diff;
    logic             trial_borrow;
    logic [WIDTH-1:0] dividend_mag;
    logic [WIDTH-1:0] divisor_mag;

    // Partial remainder with the next dividend bit shifted in from the quotient register.
    assign trial_a = {rem_q, quo_q[WIDTH-1]};
    assign trial_b = {1'b0, dvs_q};

    div_trial_sub #(.WIDTH(WIDTH)) u_trial_sub (
        .a      (trial_a),
        .b      (trial_b),
        .diff   (trial_diff),
        .borrow (trial_borrow)
    );

    assign dividend_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign divisor_mag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        orig_d      = orig_q;
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
        zero_d      = zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    count_d   = '0;
                    rem_d     = '0;
                    quo_d     = dividend_mag;
                    dvs_d     = divisor_mag;
                    orig_d    = dividend;
                    neg_quo_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    neg_rem_d = is_signed && dividend[WIDTH-1];
                    zero_d    = (divisor == '0);
                end
            end
            S_RUN: begin
                rem_d   = trial_borrow ? trial_a[WIDTH-1:0] : trial_diff;
                quo_d   = {quo_q[WIDTH-2:0], ~trial_borrow};
                count_d = count_q + CNT_W'(1);
                if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // Divide-by-zero overrides the (meaningless) iteration result.
                if (zero_q) begin
                    quotient_d  = '1;
                    remainder_d = orig_q;
                end else begin
                    quotient_d  = neg_quo_q ? -quo_q : quo_q;
                    remainder_d = neg_rem_q ? -rem_q : rem_q;
                end
                dbz_d   = zero_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            orig_q      <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            orig_q      <= orig_d;
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
            zero_q      <= zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
